// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam logic PORT_HOST = 1'b0;
   localparam logic PORT_ENG  = 1'b1;

endpackage

// File: rtl/arb_tiebreak.sv
// Combinational winner select for the idle arbitration cycle.
// ARB_RR_EN defined: ties go to the port not last served; otherwise ties go to the engine.
module arb_tiebreak
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_served,
   output logic winner
);

`ifdef ARB_RR_EN
   always_comb begin
      winner = PORT_HOST;
      if (req0 & req1) begin
         winner = ~last_served;
      end else if (req1) begin
         winner = PORT_ENG;
      end
   end
`else
   // Fixed engine priority leaves the history input without a consumer.
   logic unused_last_served;
   assign unused_last_served = last_served;

   always_comb begin
      winner = PORT_HOST;
      if (req1) begin
         winner = PORT_ENG;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Moore arbiter sharing a single-port synchronous-read memory between the host (port 0)
// and the compute engine (port 1) with bounded bursts.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned     CNT_W    = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_e       state_q, state_d;
   arb_state_e       other_state;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             last_served_q, last_served_d;
   logic             rvalid0_q, rvalid1_q;
   logic             winner;
   logic             own_req, other_req;
   logic             beat0, beat1;

   arb_tiebreak u_tiebreak (
      .req0        (req0),
      .req1        (req1),
      .last_served (last_served_q),
      .winner      (winner)
   );

   assign gnt0  = (state_q == OWN0);
   assign gnt1  = (state_q == OWN1);
   assign beat0 = gnt0 & req0;
   assign beat1 = gnt1 & req1;

   // View of the current owner and its competitor, valid only in the OWN states.
   assign own_req     = gnt1 ? req1 : req0;
   assign other_req   = gnt1 ? req0 : req1;
   assign other_state = gnt1 ? OWN0 : OWN1;

   always_comb begin
      state_d       = state_q;
      beat_cnt_d    = beat_cnt_q;
      last_served_d = last_served_q;
      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = winner ? OWN1 : OWN0;
            end
         end
         OWN0, OWN1: begin
            if (!own_req) begin
               state_d    = other_req ? other_state : IDLE;
               beat_cnt_d = '0;
            end else begin
               last_served_d = gnt1 ? PORT_ENG : PORT_HOST;
               if (beat_cnt_q == CNT_LAST) begin
                  beat_cnt_d = '0;
                  if (other_req) begin
                     state_d = other_state;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         beat_cnt_q    <= '0;
         last_served_q <= PORT_ENG;
         rvalid0_q     <= 1'b0;
         rvalid1_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_cnt_q    <= beat_cnt_d;
         last_served_q <= last_served_d;
         rvalid0_q     <= beat0 & ~we0;
         rvalid1_q     <= beat1 & ~we1;
      end
   end

   always_comb begin
      mem_en    = beat0 | beat1;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (beat0) begin
         mem_we    = we0;
         mem_addr  = addr0;
         mem_wdata = wdata0;
      end else if (beat1) begin
         mem_we    = we1;
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = mem_rdata;
   assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic,
// all compared cycle by cycle against a transaction-level arbitration model.
module tb_mem_port_arbiter;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory macro: synchronous read, one cycle latency.
   logic [DW-1:0] tb_mem [16];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= tb_mem[mem_addr];
      end
   end

   // Reference model: who owns the port, beats spent in this grant, last port served.
   int            owner;
   int            served;
   int            last;
   bit            exp_rv [2];
   logic [DW-1:0] exp_rd [2];
   logic [DW-1:0] ref_mem [16];
   bit            served_flag [2];
   int            rem [2];
   bit            stream_we [2];
   bit            rnd;
   int            total, bad, dut_beats;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int tie_winner();
`ifdef ARB_RR_EN
      return 1 - last;
`else
      return 1;
`endif
   endfunction

   task automatic model_reset();
      owner = -1; served = 0; last = 1;
      exp_rv[0] = 0; exp_rv[1] = 0;
   endtask

   task automatic set_port(input int k, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (k == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic new_txn(input int k, input bit w);
      set_port(k, 1'b1, w, AW'($urandom_range(0, 15)), DW'($urandom));
   endtask

   task automatic start(input int k, input int n, input bit w);
      rem[k] = n; stream_we[k] = w;
      new_txn(k, w);
   endtask

   task automatic check_outputs();
      bit            b0, b1;
      logic          e_we;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      b0 = (owner == 0) && req0;
      b1 = (owner == 1) && req1;
      e_we = b0 ? we0 : (b1 ? we1 : 1'b0);
      e_a  = b0 ? addr0 : (b1 ? addr1 : '0);
      e_d  = b0 ? wdata0 : (b1 ? wdata1 : '0);
      chk("gnt0", 32'(gnt0), 32'(owner == 0));
      chk("gnt1", 32'(gnt1), 32'(owner == 1));
      chk("mem_en", 32'(mem_en), 32'(b0 | b1));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_a));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_d));
      chk("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
      chk("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
      if (exp_rv[0]) chk("rdata0", 32'(rdata0), 32'(exp_rd[0]));
      if (exp_rv[1]) chk("rdata1", 32'(rdata1), 32'(exp_rd[1]));
      if (mem_en === 1'b1) dut_beats++;
   endtask

   task automatic model_edge();
      bit            r [2];
      bit            w [2];
      logic [AW-1:0] a [2];
      logic [DW-1:0] d [2];
      int            k, o;
      r[0] = req0; r[1] = req1; w[0] = we0; w[1] = we1;
      a[0] = addr0; a[1] = addr1; d[0] = wdata0; d[1] = wdata1;
      served_flag[0] = 0; served_flag[1] = 0;
      exp_rv[0] = 0; exp_rv[1] = 0;
      if (owner < 0) begin
         if (r[0] && r[1]) owner = tie_winner();
         else if (r[0])    owner = 0;
         else if (r[1])    owner = 1;
      end else begin
         k = owner; o = 1 - k;
         if (r[k]) begin
            served_flag[k] = 1;
            last = k;
            if (w[k]) ref_mem[a[k]] = d[k];
            else begin exp_rv[k] = 1; exp_rd[k] = ref_mem[a[k]]; end
            served++;
            if (served == MB) begin
               served = 0;
               if (r[o]) owner = o;
            end
         end else begin
            served = 0;
            owner = r[o] ? o : -1;
         end
      end
   endtask

   task automatic advance_requesters();
      bit r;
      for (int k = 0; k < 2; k++) begin
         r = (k == 0) ? req0 : req1;
         if (served_flag[k]) begin
            rem[k]--;
            if (rem[k] <= 0) begin
               rem[k] = 0;
               set_port(k, 1'b0, 1'b0, '0, '0);
            end else begin
               new_txn(k, rnd ? 1'($urandom_range(0, 1)) : stream_we[k]);
            end
         end else if (rnd && !r && $urandom_range(0, 2) == 0) begin
            start(k, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
         end else if (rnd && r && owner != k && $urandom_range(0, 15) == 0) begin
            rem[k] = 0;
            set_port(k, 1'b0, 1'b0, '0, '0);
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
      advance_requesters();
   endtask

   task automatic drain();
      int n = 0;
      while ((req0 || req1) && n < 200) begin cycle(); n++; end
      chk("drain_timeout", 32'(n < 200), 32'd1);
      cycle(); cycle();
   endtask

   task automatic clear_reqs();
      rem[0] = 0; rem[1] = 0;
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      total = 0; bad = 0; dut_beats = 0; rnd = 0;
      for (int i = 0; i < 16; i++) begin
         tb_mem[i] = DW'($urandom);
         ref_mem[i] = tb_mem[i];
      end
      clear_reqs();
      model_reset();

      // Asynchronous reset state, checked before any clock edge.
      rst = 1'b0;
      #2;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Single host write of A5A5 to addr 3, then read it back.
      rem[0] = 1; set_port(0, 1'b1, 1'b1, 4'd3, 16'hA5A5);
      cycle();
      chk("t1_gnt0", 32'(gnt0), 32'd1);
      chk("t1_mem_we", 32'(mem_we), 32'd1);
      chk("t1_mem_addr", 32'(mem_addr), 32'd3);
      cycle(); cycle();
      chk("t1_idle", 32'(gnt0), 32'd0);
      rem[0] = 1; set_port(0, 1'b1, 1'b0, 4'd3, '0);
      cycle(); cycle();
      chk("t1_rvalid0", 32'(rvalid0), 32'd1);
      chk("t1_rdata0", 32'(rdata0), 32'hA5A5);
      cycle();

      // Port 1 streams ten reads alone: no handover, one long grant.
      dut_beats = 0;
      start(1, 10, 1'b0);
      drain();
      chk("t2_beats", 32'(dut_beats), 32'd10);

      // Tie from idle with port 1 last served.
      start(0, 1, 1'b0); start(1, 1, 1'b0);
      cycle();
`ifdef ARB_RR_EN
      chk("tie1_gnt1", 32'(gnt1), 32'd0);
`else
      chk("tie1_gnt1", 32'(gnt1), 32'd1);
`endif
      drain();
      start(0, 1, 1'b1);
      drain();
      start(0, 1, 1'b0); start(1, 1, 1'b0);
      cycle();
      chk("tie2_gnt1", 32'(gnt1), 32'd1);
      drain();

      // Port 0 arrives mid-burst: forced handover after MAX_BURST beats.
      start(1, 9, 1'b0);
      cycle(); cycle();
      start(0, 2, 1'b0);
      drain();

      // Port 1 quits after two beats while port 0 waits.
      start(1, 2, 1'b0);
      cycle();
      start(0, 6, 1'b1);
      drain();

      // Asynchronous reset in the middle of a port 1 read burst.
      start(1, 12, 1'b0);
      cycle(); cycle(); cycle(); cycle();
      #2 rst = 1'b0;
      #1;
      chk("arst_gnt1", 32'(gnt1), 32'd0);
      chk("arst_rvalid1", 32'(rvalid1), 32'd0);
      chk("arst_mem_en", 32'(mem_en), 32'd0);
      model_reset();
      clear_reqs();
      @(posedge clk); #1 rst = 1'b1;
      start(0, 1, 1'b0); start(1, 1, 1'b0);
      cycle();
`ifdef ARB_RR_EN
      chk("arst_tie_gnt0", 32'(gnt0), 32'd1);
`else
      chk("arst_tie_gnt0", 32'(gnt0), 32'd0);
`endif
      drain();

      // Random traffic on both ports.
      rnd = 1;
      for (int i = 0; i < 3000; i++) cycle();
      rnd = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
